// File: rtl/counter_arbiter_ctrl.sv
// Two-requester round-robin arbiter that runs a shared up-counter for the winner.
// Latency: grant one falling edge after req; run is lim+1 COUNT edges, then DONE, then IDLE.
// Backpressure: none; the granted requester aborts the run by dropping its req.
module counter_arbiter_ctrl #(
    parameter int W = 4
) (
    input  logic         Ck,
    input  logic         reset_,
    input  logic [1:0]   req,
    input  logic [W-1:0] len0,
    input  logic [W-1:0] len1,
    output logic [1:0]   gnt,
    output logic         busy,
    output logic [1:0]   done,
    output logic [W-1:0] Q
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t       state, state_nxt;
    logic         ptr, ptr_nxt;
    logic [W-1:0] lim, lim_nxt;
    logic [1:0]   gnt_nxt;
    logic         busy_nxt;
    logic [1:0]   done_nxt;
    logic [W-1:0] q_nxt;
    logic         win;
    logic         cur;

    // Pointer only breaks ties; a lone request always wins.
    assign win = (req == 2'b11) ? ptr : req[1];
    assign cur = gnt[1];

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        lim_nxt   = lim;
        gnt_nxt   = gnt;
        busy_nxt  = busy;
        done_nxt  = 2'b00;
        q_nxt     = Q;
        case (state)
            IDLE: begin
                gnt_nxt  = 2'b00;
                busy_nxt = 1'b0;
                q_nxt    = '0;
                if (req != 2'b00) begin
                    state_nxt = COUNT;
                    lim_nxt   = win ? len1 : len0;
                    gnt_nxt   = win ? 2'b10 : 2'b01;
                    busy_nxt  = 1'b1;
                end
            end
            COUNT: begin
                if (!req[cur]) begin
                    state_nxt = IDLE;
                    gnt_nxt   = 2'b00;
                    busy_nxt  = 1'b0;
                    q_nxt     = '0;
                    ptr_nxt   = ~cur;
                end else if (Q == lim) begin
                    state_nxt = DONE;
                    done_nxt  = gnt;
                end else begin
                    q_nxt = Q + 1'b1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
                gnt_nxt   = 2'b00;
                busy_nxt  = 1'b0;
                q_nxt     = '0;
                ptr_nxt   = ~cur;
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = 2'b00;
                busy_nxt  = 1'b0;
                q_nxt     = '0;
            end
        endcase
    end

    always_ff @(negedge Ck or negedge reset_) begin
        if (!reset_) begin
            state <= IDLE;
            ptr   <= 1'b0;
            lim   <= '0;
            gnt   <= 2'b00;
            busy  <= 1'b0;
            done  <= 2'b00;
            Q     <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            lim   <= lim_nxt;
            gnt   <= gnt_nxt;
            busy  <= busy_nxt;
            done  <= done_nxt;
            Q     <= q_nxt;
        end
    end

endmodule
